// File: rtl/ftq_read_arbiter.sv
// ftq_read_arbiter
//   Shares the BRU_NUM FTQ read ports between the ROB (exception/redirect PC
//   lookup) and the branch units. Port p belongs to BRU p. The ROB borrows
//   the highest-indexed idle port. If every BRU is requesting, it takes port 0
//   and BRU0 is denied. A bounded age counter lets BRU0 win after STARVE_LIM
//   consecutive denials. The read index is driven combinationally. Read data
//   is registered and returned one cycle after the grant.
//
//   Optional feature macro: FTQ_ARB_PERF_EN (adds two saturating perf counters).
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_squash_vld                  backend squash (drops next-cycle BRU responses)
//   i_bru_req_vld/_idx            per-BRU read request and ftqIdx
//   o_bru_req_rdy                 per-BRU grant (same cycle)
//   o_bru_resp_vld                per-BRU response valid (one cycle after grant)
//   o_bru_startAddr/_nextAddr     registered FTQ data per BRU
//   i_rob_req_vld/_idx            ROB read request and ftqIdx
//   o_rob_req_rdy                 ROB grant (same cycle)
//   o_rob_resp_vld                ROB response valid
//   o_rob_startAddr               registered startAddr for ROB
//   o_read_ftqIdx                 FTQ read index per port
//   i_read_ftqStartAddr/NextAddr  FTQ read data per port, same cycle as index
//   o_perf_rob_stall_cnt          (FTQ_ARB_PERF_EN) cycles ROB requested and was denied
//   o_perf_bru0_deny_cnt          (FTQ_ARB_PERF_EN) cycles BRU0 requested and was denied
module ftq_read_arbiter #(
  parameter int BRU_NUM    = 2,
  parameter int FTQIDX_W   = 4,
  parameter int XLEN       = 64,
  parameter int STARVE_LIM = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_squash_vld,
  input  logic [BRU_NUM-1:0]                 i_bru_req_vld,
  input  logic [BRU_NUM-1:0][FTQIDX_W-1:0]   i_bru_req_idx,
  output logic [BRU_NUM-1:0]                 o_bru_req_rdy,
  output logic [BRU_NUM-1:0]                 o_bru_resp_vld,
  output logic [BRU_NUM-1:0][XLEN-1:0]       o_bru_startAddr,
  output logic [BRU_NUM-1:0][XLEN-1:0]       o_bru_nextAddr,
  input  logic                               i_rob_req_vld,
  input  logic [FTQIDX_W-1:0]                i_rob_req_idx,
  output logic                               o_rob_req_rdy,
  output logic                               o_rob_resp_vld,
  output logic [XLEN-1:0]                    o_rob_startAddr,
  output logic [BRU_NUM-1:0][FTQIDX_W-1:0]   o_read_ftqIdx,
  input  logic [BRU_NUM-1:0][XLEN-1:0]       i_read_ftqStartAddr,
  input  logic [BRU_NUM-1:0][XLEN-1:0]       i_read_ftqNextAddr
`ifdef FTQ_ARB_PERF_EN
  ,
  output logic [31:0]                        o_perf_rob_stall_cnt,
  output logic [31:0]                        o_perf_bru0_deny_cnt
`endif
);

  localparam int CNT_W  = $clog2(STARVE_LIM + 1);
  localparam int PORT_W = (BRU_NUM > 1) ? $clog2(BRU_NUM) : 1;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0]               starve_cnt_q, starve_cnt_d;
  logic [PORT_W-1:0]              rob_port;
  logic                           free_found;
  logic                           rob_gnt;
  logic [BRU_NUM-1:0]             rob_on;
  logic [BRU_NUM-1:0]             bru_gnt;

  logic [BRU_NUM-1:0]             bru_resp_vld_q;
  logic [BRU_NUM-1:0][XLEN-1:0]   bru_start_q, bru_next_q;
  logic                           rob_resp_vld_q;
  logic [XLEN-1:0]                rob_start_q;

  // Port selection looks only at request valids and the age counter, never
  // at any requester's index.
  always_comb begin
    free_found = 1'b0;
    rob_port   = '0;
    // Later iterations overwrite, so the highest-indexed idle port wins.
    for (int p = 0; p < BRU_NUM; p++) begin
      if (!i_bru_req_vld[p]) begin
        free_found = 1'b1;
        rob_port   = PORT_W'(p);
      end
    end

    rob_gnt = 1'b0;
    if (i_rob_req_vld) begin
      if (free_found) begin
        rob_gnt = 1'b1;
      end else if (starve_cnt_q != STARVE_MAX) begin
        // All BRUs busy: ROB steals port 0 unless BRU0 has waited too long.
        rob_gnt  = 1'b1;
        rob_port = '0;
      end
    end

    for (int p = 0; p < BRU_NUM; p++) begin
      rob_on[p]        = rob_gnt && (rob_port == PORT_W'(p));
      bru_gnt[p]       = i_bru_req_vld[p] && !rob_on[p];
      o_read_ftqIdx[p] = rob_on[p] ? i_rob_req_idx : i_bru_req_idx[p];
    end
  end

  assign o_bru_req_rdy = bru_gnt;
  assign o_rob_req_rdy = rob_gnt;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (i_squash_vld) begin
      starve_cnt_d = '0;
    end else if (i_bru_req_vld[0] && !bru_gnt[0]) begin
      if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
    end else if (bru_gnt[0]) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q   <= '0;
      bru_resp_vld_q <= '0;
      bru_start_q    <= '0;
      bru_next_q     <= '0;
      rob_resp_vld_q <= 1'b0;
      rob_start_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      for (int p = 0; p < BRU_NUM; p++) begin
        // A squashed grant still loads data; only the valid is suppressed.
        bru_resp_vld_q[p] <= bru_gnt[p] && !i_squash_vld;
        if (bru_gnt[p]) begin
          bru_start_q[p] <= i_read_ftqStartAddr[p];
          bru_next_q[p]  <= i_read_ftqNextAddr[p];
        end
      end
      rob_resp_vld_q <= rob_gnt;
      if (rob_gnt) rob_start_q <= i_read_ftqStartAddr[rob_port];
    end
  end

  assign o_bru_resp_vld  = bru_resp_vld_q;
  assign o_bru_startAddr = bru_start_q;
  assign o_bru_nextAddr  = bru_next_q;
  assign o_rob_resp_vld  = rob_resp_vld_q;
  assign o_rob_startAddr = rob_start_q;

`ifdef FTQ_ARB_PERF_EN
  logic [31:0] perf_rob_stall_q, perf_bru0_deny_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rob_stall_q <= '0;
      perf_bru0_deny_q <= '0;
    end else begin
      if (i_rob_req_vld && !rob_gnt && (perf_rob_stall_q != '1))
        perf_rob_stall_q <= perf_rob_stall_q + 32'd1;
      if (i_bru_req_vld[0] && !bru_gnt[0] && (perf_bru0_deny_q != '1))
        perf_bru0_deny_q <= perf_bru0_deny_q + 32'd1;
    end
  end

  assign o_perf_rob_stall_cnt = perf_rob_stall_q;
  assign o_perf_bru0_deny_cnt = perf_bru0_deny_q;
`endif

endmodule

// File: tb/tb_ftq_read_arbiter.sv
// Self-checking bench for ftq_read_arbiter (BRU_NUM=2, FTQIDX_W=4, XLEN=64,
// STARVE_LIM=3). A small FTQ model returns data derived from (port, idx),
// so a wrong port or index shows up as wrong data.
module tb_ftq_read_arbiter;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_squash_vld;
  logic [1:0]         i_bru_req_vld;
  logic [1:0][3:0]    i_bru_req_idx;
  logic [1:0]         o_bru_req_rdy;
  logic [1:0]         o_bru_resp_vld;
  logic [1:0][63:0]   o_bru_startAddr;
  logic [1:0][63:0]   o_bru_nextAddr;
  logic               i_rob_req_vld;
  logic [3:0]         i_rob_req_idx;
  logic               o_rob_req_rdy;
  logic               o_rob_resp_vld;
  logic [63:0]        o_rob_startAddr;
  logic [1:0][3:0]    o_read_ftqIdx;
  logic [1:0][63:0]   i_read_ftqStartAddr;
  logic [1:0][63:0]   i_read_ftqNextAddr;
`ifdef FTQ_ARB_PERF_EN
  logic [31:0]        o_perf_rob_stall_cnt;
  logic [31:0]        o_perf_bru0_deny_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  ftq_read_arbiter #(.BRU_NUM(2), .FTQIDX_W(4), .XLEN(64), .STARVE_LIM(3)) dut (
    .clk(clk), .rst(rst), .i_squash_vld(i_squash_vld),
    .i_bru_req_vld(i_bru_req_vld), .i_bru_req_idx(i_bru_req_idx),
    .o_bru_req_rdy(o_bru_req_rdy), .o_bru_resp_vld(o_bru_resp_vld),
    .o_bru_startAddr(o_bru_startAddr), .o_bru_nextAddr(o_bru_nextAddr),
    .i_rob_req_vld(i_rob_req_vld), .i_rob_req_idx(i_rob_req_idx),
    .o_rob_req_rdy(o_rob_req_rdy), .o_rob_resp_vld(o_rob_resp_vld),
    .o_rob_startAddr(o_rob_startAddr), .o_read_ftqIdx(o_read_ftqIdx),
    .i_read_ftqStartAddr(i_read_ftqStartAddr), .i_read_ftqNextAddr(i_read_ftqNextAddr)
`ifdef FTQ_ARB_PERF_EN
    , .o_perf_rob_stall_cnt(o_perf_rob_stall_cnt), .o_perf_bru0_deny_cnt(o_perf_bru0_deny_cnt)
`endif
  );

  function automatic logic [63:0] ftq_start(input int p, input logic [3:0] idx);
    return 64'h4000_0000_0000_0000 + 64'(p) * 64'h100 + 64'(idx) * 64'h10;
  endfunction
  function automatic logic [63:0] ftq_next(input int p, input logic [3:0] idx);
    return ftq_start(p, idx) + 64'h0000_0000_1000_0000;
  endfunction

  // FTQ storage model: data follows the index the arbiter drives.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      i_read_ftqStartAddr[p] = ftq_start(p, o_read_ftqIdx[p]);
      i_read_ftqNextAddr[p]  = ftq_next(p, o_read_ftqIdx[p]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  int          m_starve;
  logic [1:0]  m_bru_vld;
  logic [63:0] m_bru_start [2];
  logic [63:0] m_bru_next  [2];
  logic        m_rob_vld;
  logic [63:0] m_rob_start;

  logic        e_rob_rdy;
  int          e_rob_port;
  logic [1:0]  e_bru_rdy;
  logic [1:0][3:0] e_idx;

  // Arbitration rules: ROB takes the top idle port; with none idle it takes
  // port 0 unless BRU0 has been denied STARVE_LIM times in a row.
  always_comb begin
    e_rob_port = -1;
    for (int p = 0; p < 2; p++) if (!i_bru_req_vld[p]) e_rob_port = p;
    e_rob_rdy = 1'b0;
    if (i_rob_req_vld) begin
      if (e_rob_port >= 0) e_rob_rdy = 1'b1;
      else if (m_starve < 3) begin
        e_rob_rdy  = 1'b1;
        e_rob_port = 0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      e_bru_rdy[p] = i_bru_req_vld[p] && !(e_rob_rdy && e_rob_port == p);
      e_idx[p]     = (e_rob_rdy && e_rob_port == p) ? i_rob_req_idx : i_bru_req_idx[p];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_starve  <= 0;
      m_bru_vld <= 2'b00;
      m_rob_vld <= 1'b0;
      m_rob_start <= 64'd0;
      for (int p = 0; p < 2; p++) begin
        m_bru_start[p] <= 64'd0;
        m_bru_next[p]  <= 64'd0;
      end
    end else begin
      m_rob_vld <= e_rob_rdy;
      if (e_rob_rdy) m_rob_start <= ftq_start(e_rob_port, i_rob_req_idx);
      for (int p = 0; p < 2; p++) begin
        m_bru_vld[p] <= e_bru_rdy[p] && !i_squash_vld;
        if (e_bru_rdy[p]) begin
          m_bru_start[p] <= ftq_start(p, i_bru_req_idx[p]);
          m_bru_next[p]  <= ftq_next(p, i_bru_req_idx[p]);
        end
      end
      if (i_squash_vld) m_starve <= 0;
      else if (i_bru_req_vld[0] && !e_bru_rdy[0]) m_starve <= (m_starve < 3) ? m_starve + 1 : 3;
      else if (e_bru_rdy[0]) m_starve <= 0;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("bru_req_rdy", 64'(o_bru_req_rdy), 64'(e_bru_rdy));
      chk("rob_req_rdy", 64'(o_rob_req_rdy), 64'(e_rob_rdy));
      chk("read_ftqIdx", 64'(o_read_ftqIdx), 64'(e_idx));
      chk("bru_resp_vld", 64'(o_bru_resp_vld), 64'(m_bru_vld));
      chk("rob_resp_vld", 64'(o_rob_resp_vld), 64'(m_rob_vld));
      chk("rob_startAddr", o_rob_startAddr, m_rob_start);
      for (int p = 0; p < 2; p++) begin
        chk("bru_startAddr", o_bru_startAddr[p], m_bru_start[p]);
        chk("bru_nextAddr", o_bru_nextAddr[p], m_bru_next[p]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_bru_req_vld = 2'b00;
    i_rob_req_vld = 1'b0;
    i_squash_vld  = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_rob_win;
    logic [4:0] exp_bru0_win;
    rst = 1'b1;
    i_bru_req_idx = '0;
    i_rob_req_idx = '0;
    idle();
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    chk("reset_bru_resp_vld", 64'(o_bru_resp_vld), 64'd0);
    chk("reset_rob_resp_vld", 64'(o_rob_resp_vld), 64'd0);
    chk("reset_rob_start", o_rob_startAddr, 64'd0);
    chk("reset_bru_start0", o_bru_startAddr[0], 64'd0);
    chk("idle_rdy", 64'({o_rob_req_rdy, o_bru_req_rdy}), 64'd0);

    // Conflict-free: ROB borrows idle port 1.
    tick();
    i_bru_req_vld = 2'b01; i_bru_req_idx[0] = 4'd3;
    i_rob_req_vld = 1'b1;  i_rob_req_idx = 4'd5;
    #3;
    chk("cf_idx1", 64'(o_read_ftqIdx[1]), 64'd5);
    chk("cf_idx0", 64'(o_read_ftqIdx[0]), 64'd3);
    chk("cf_rdy", 64'({o_rob_req_rdy, o_bru_req_rdy}), 64'b101);
    tick();
    idle();
    #3;
    chk("cf_rob_resp", 64'(o_rob_resp_vld), 64'd1);
    chk("cf_rob_start", o_rob_startAddr, 64'h4000_0000_0000_0150);
    chk("cf_bru_resp", 64'(o_bru_resp_vld), 64'b01);
    chk("cf_bru0_start", o_bru_startAddr[0], 64'h4000_0000_0000_0030);
    chk("cf_bru0_next", o_bru_nextAddr[0], 64'h4000_0000_1000_0030);

    // Conflict: all request, ROB takes port 0.
    tick();
    i_bru_req_vld = 2'b11; i_bru_req_idx[0] = 4'd2; i_bru_req_idx[1] = 4'd7;
    i_rob_req_vld = 1'b1;  i_rob_req_idx = 4'd9;
    #3;
    chk("cx_rob_rdy", 64'(o_rob_req_rdy), 64'd1);
    chk("cx_idx0", 64'(o_read_ftqIdx[0]), 64'd9);
    chk("cx_bru_rdy", 64'(o_bru_req_rdy), 64'b10);

    // BRU0 alone clears the age counter.
    tick();
    i_bru_req_vld = 2'b01; i_rob_req_vld = 1'b0;
    tick();

    // Starvation: all three request for five cycles.
    exp_rob_win  = 5'b10111;
    exp_bru0_win = 5'b01000;
    i_bru_req_vld = 2'b11; i_rob_req_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("starve_rob_rdy", 64'(o_rob_req_rdy), 64'(exp_rob_win[c]));
      chk("starve_bru0_rdy", 64'(o_bru_req_rdy[0]), 64'(exp_bru0_win[c]));
      tick();
    end

    // Squash: BRU1 granted under squash, ROB on port 0 still responds.
    i_bru_req_vld = 2'b10; i_bru_req_idx[1] = 4'd4;
    i_rob_req_vld = 1'b1;  i_rob_req_idx = 4'd6;
    i_squash_vld  = 1'b1;
    tick();
    idle();
    #3;
    chk("sq_bru_resp", 64'(o_bru_resp_vld), 64'd0);
    chk("sq_rob_resp", 64'(o_rob_resp_vld), 64'd1);
    chk("sq_rob_start", o_rob_startAddr, 64'h4000_0000_0000_0060);

    // A response already valid in the squash cycle is still presented.
    tick();
    i_bru_req_vld = 2'b10; i_bru_req_idx[1] = 4'd8;
    tick();
    i_bru_req_vld = 2'b00; i_squash_vld = 1'b1;
    #3;
    chk("sq_prior_resp", 64'(o_bru_resp_vld), 64'b10);
    tick();
    idle();

    // Reset the cycle after a grant.
    i_bru_req_vld = 2'b01; i_bru_req_idx[0] = 4'd1;
    tick();
    idle(); rst = 1'b1;
    tick();
    #3;
    chk("rst_bru_resp", 64'(o_bru_resp_vld), 64'd0);
    chk("rst_rob_resp", 64'(o_rob_resp_vld), 64'd0);
    chk("rst_bru_start0", o_bru_startAddr[0], 64'd0);
    chk("rst_rob_start", o_rob_startAddr, 64'd0);

    // Reset during a grant discards the pending response.
    i_bru_req_vld = 2'b01; i_bru_req_idx[0] = 4'd2; i_rob_req_vld = 1'b1;
    tick();
    idle(); rst = 1'b0;
    #3;
    chk("rst_discard", 64'({o_rob_resp_vld, o_bru_resp_vld}), 64'd0);

    // Sweep of request/squash combinations, checked by the model.
    for (int i = 0; i < 24; i++) begin
      tick();
      i_bru_req_vld    = 2'(i);
      i_rob_req_vld    = (i % 3) != 0;
      i_squash_vld     = (i % 7) == 5;
      i_bru_req_idx[0] = 4'((i * 3) % 16);
      i_bru_req_idx[1] = 4'((i * 5 + 1) % 16);
      i_rob_req_idx    = 4'((i * 7 + 2) % 16);
    end
    tick();
    idle();

`ifdef FTQ_ARB_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_bru_req_vld = 2'b11; i_rob_req_vld = 1'b1;
    repeat (20) tick();
    idle();
    #3;
    chk("perf_rob_stall", 64'(o_perf_rob_stall_cnt), 64'd5);
    chk("perf_bru0_deny", 64'(o_perf_bru0_deny_cnt), 64'd15);
    force dut.perf_rob_stall_q = 32'hFFFF_FFFE;
    tick();
    release dut.perf_rob_stall_q;
    i_bru_req_vld = 2'b11; i_rob_req_vld = 1'b1;
    repeat (8) tick();
    idle();
    #3;
    chk("perf_rob_sat", 64'(o_perf_rob_stall_cnt), 64'hFFFF_FFFF);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ftq_read_arbiter.md
Name: ftq_read_arbiter

Overview:
- Arbitrates the BRU_NUM FTQ read ports between the ROB read requester (exception/redirect PC lookup) and the BRU_NUM branch units.
- Replaces the fixed ROB-overrides-port-0 steering in the backend top level.
- Drives the FTQ read index combinationally.
- Registers the FTQ read data and returns it to the winning requester one cycle later.
- Prevents BRU0 starvation with a bounded age counter.

Parameters:
- BRU_NUM, 2, number of BRUs and number of FTQ read ports (port i is owned by BRU i).
- FTQIDX_W, 4, ftqIdx width.
- XLEN, 64, address width.
- STARVE_LIM, 3, consecutive BRU0 denials before BRU0 overrides ROB.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_squash_vld  in  1  backend squash.
- i_bru_req_vld  in  BRU_NUM  BRU i read request.
- i_bru_req_idx  in  BRU_NUM x FTQIDX_W  BRU i ftqIdx.
- o_bru_req_rdy  out  BRU_NUM  BRU i granted this cycle.
- o_bru_resp_vld  out  BRU_NUM  BRU i response valid.
- o_bru_startAddr  out  BRU_NUM x XLEN  registered FTQ startAddr.
- o_bru_nextAddr  out  BRU_NUM x XLEN  registered FTQ nextAddr.
- i_rob_req_vld  in  1  ROB read request.
- i_rob_req_idx  in  FTQIDX_W  ROB ftqIdx.
- o_rob_req_rdy  out  1  ROB granted this cycle.
- o_rob_resp_vld  out  1  ROB response valid.
- o_rob_startAddr  out  XLEN  registered startAddr for ROB.
- o_read_ftqIdx  out  BRU_NUM x FTQIDX_W  FTQ read index per port.
- i_read_ftqStartAddr  in  BRU_NUM x XLEN  FTQ data, same cycle as index.
- i_read_ftqNextAddr  in  BRU_NUM x XLEN  FTQ data, same cycle as index.

Behaviour:
- Grant rule (combinational):
  - BRU i with no ROB conflict is always granted.
  - ROB, if requesting, takes the highest-indexed port p whose BRU p is not requesting; that BRU is idle, so no BRU loses.
  - If all BRUs request, ROB takes port 0 and BRU0 is denied (o_bru_req_rdy[0]=0).
  - Exception: if starve_cnt == STARVE_LIM, BRU0 wins port 0 and o_rob_req_rdy=0.
- Handshake:
  - req_vld/req_rdy transfer on the same edge.
  - A denied requester must hold vld and idx stable; holding is not checked.
  - rdy never depends on the requester's own idx.
- o_read_ftqIdx[p]:
  - ROB idx if ROB is granted on p.
  - Else i_bru_req_idx[p] (driven even when not requesting).
- starve_cnt:
  - Width clog2(STARVE_LIM+1); reset 0.
  - Increments when i_bru_req_vld[0] && !o_bru_req_rdy[0].
  - Clears when BRU0 is granted.
  - Holds when BRU0 is idle.
  - Never exceeds STARVE_LIM.
- Response (latency 1):
  - At the edge after grant, the data registers capture i_read_ftqStartAddr/NextAddr of the granted port.
  - The corresponding resp_vld goes 1 for exactly one cycle.
  - Data registers only update on grant; otherwise they hold.
- Squash:
  - A BRU grant in a cycle with i_squash_vld=1 produces no BRU response next cycle (o_bru_resp_vld stays 0).
  - A BRU response already valid in the squash cycle is still presented.
  - The ROB path is unaffected by squash: the ROB reads the squash PC.
  - starve_cnt clears on squash.
- Reset:
  - All resp_vld=0, all address outputs=0, starve_cnt=0.
  - Combinational rdy/idx outputs follow inputs; with all requests low, rdy=0.
  - Reset mid-transfer discards any pending response.
- Only the ROB ever loses arbitration besides BRU0; BRUs 1..BRU_NUM-1 are never denied.

Optional Feature:
- FTQ_ARB_PERF_EN:
  - When defined, adds o_perf_rob_stall_cnt (32 bits: cycles ROB requests and is denied).
  - Adds o_perf_bru0_deny_cnt (32 bits: cycles BRU0 requests and is denied).
  - Both counters saturate at all-ones, reset to 0, and do not clear on squash.
- When undefined, these ports and counters do not exist; arbitration is unchanged.

Test Plan:
- Conflict-free ROB request: BRU0 req idx=3, ROB req idx=5, BRU1 idle.
  -> ROB on port1 (o_read_ftqIdx[1]=5), both rdy=1.
  -> Next cycle o_rob_resp_vld=1 with startAddr of port1, o_bru_resp_vld[0]=1.
- Conflict: both BRUs and ROB request.
  -> o_rob_req_rdy=1, o_read_ftqIdx[0]=ROB idx, o_bru_req_rdy[0]=0, o_bru_req_rdy[1]=1.
- Starvation: all three request continuously (STARVE_LIM=3).
  -> Cycles 0-2: ROB wins port 0.
  -> Cycle 3: BRU0 wins and o_rob_req_rdy=0.
  -> Cycle 4: ROB wins again, starve_cnt=0.
- Squash: BRU1 granted with i_squash_vld=1.
  -> Next cycle o_bru_resp_vld[1]=0.
  -> ROB granted in the same cycle still returns o_rob_resp_vld=1.
- Reset: assert rst the cycle after a grant.
  -> All resp_vld=0, addresses 0, starve_cnt=0.
- With FTQ_ARB_PERF_EN: 5 ROB-denied cycles.
  -> o_perf_rob_stall_cnt=5; force near all-ones and confirm saturation.
